// File: rtl/module_display_ctrl.sv
// -----------------------------------------------------------------------------
// module_display_ctrl
//   Sequences one shared binary-to-BCD decoder between operand A and operand B,
//   stores the four resulting digit codes, and scans them onto a 4-digit
//   common-anode 7-segment display.
//
//   Optional build macro: DISPLAY_LZB_EN
//     defined   -> an in-range operand with a zero tens digit shows a blank tens
//     undefined -> the tens digit is always shown ("05")
//
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     a_i     operand A (unsigned binary, 8 bit)
//     b_i     operand B (unsigned binary, 8 bit)
//     upd_i   update request, sampled only while idle
//     busy_o  high while a conversion sequence runs (registered)
//     done_o  one-cycle pulse once both operands are captured (registered)
//     an_o    digit anodes, active-low one-hot: [3]=A tens [2]=A units
//             [1]=B tens [0]=B units
//     seg_o   segments gfedcba, active-low
// -----------------------------------------------------------------------------

// Combinational binary-to-BCD split for values 0..99. Outputs for inputs above
// 99 are don't-care; the controller substitutes dashes for those.
module module_decobinabcd (
   input  logic [7:0] b,
   output logic [3:0] dec,
   output logic [3:0] uni
);
   always_comb begin
      dec = 4'd0;
      for (int t = 1; t <= 9; t++) begin
         if (b >= 8'(t * 10)) dec = 4'(t);
      end
      uni = 4'(b - (8'(dec) * 8'd10));
   end
endmodule

module module_display_ctrl #(
   parameter int REFRESH_DIV = 27000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       upd_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] an_o,
   output logic [6:0] seg_o
);
   localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [3:0] CODE_DASH  = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {IDLE, SEL_A, SEL_B} state_t;

   state_t           state_q, state_d;
   logic [7:0]       sha_q, sha_d;
   logic [7:0]       shb_q, shb_d;
   logic [3:0][3:0]  dig_q, dig_d;      // dig_q[3..0] = d3..d0
   logic [RC_W-1:0]  rc_q, rc_d;
   logic [1:0]       di_q, di_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [7:0]       dec_in;
   logic [3:0]       dec_tens, dec_units;
   logic [3:0]       tens_code, units_code;
   logic             rc_wrap;

   function automatic logic [6:0] seg_pattern(input logic [3:0] code);
      case (code)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         4'hA:    return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   // The single decoder sees operand B only while SEL_B; otherwise operand A.
   assign dec_in = (state_q == SEL_B) ? shb_q : sha_q;

   module_decobinabcd u_dec (
      .b   (dec_in),
      .dec (dec_tens),
      .uni (dec_units)
   );

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      tens_code  = dec_tens;
      units_code = dec_units;
      if (dec_in > 8'd99) begin
         tens_code  = CODE_DASH;
         units_code = CODE_DASH;
      end
`ifdef DISPLAY_LZB_EN
      else if (dec_tens == 4'd0) begin
         tens_code = CODE_BLANK;
      end
`else
`endif
   end

   always_comb begin
      state_d = state_q;
      sha_d   = sha_q;
      shb_d   = shb_q;
      dig_d   = dig_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (upd_i) begin
               sha_d   = a_i;
               shb_d   = b_i;
               state_d = SEL_A;
            end
         end
         SEL_A: begin
            dig_d[3] = tens_code;
            dig_d[2] = units_code;
            state_d  = SEL_B;
         end
         SEL_B: begin
            dig_d[1] = tens_code;
            dig_d[0] = units_code;
            state_d  = IDLE;
            done_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);

      // Free-running scan; the display registers are computed from next-state
      // values so a digit capture shows up on the same edge it is stored.
      rc_wrap = (rc_q == RC_W'(REFRESH_DIV - 1));
      rc_d    = rc_wrap ? '0 : rc_q + 1'b1;
      di_d    = rc_wrap ? di_q + 2'd1 : di_q;
      an_d    = ~(4'b0001 << di_d);
      seg_d   = seg_pattern(dig_d[di_d]);
   end

   // NOTE: sequential state uses non-blocking assignments only, and every
   // register (including the digit bank) has an explicit async reset value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         dig_q   <= {4{CODE_BLANK}};
         rc_q    <= '0;
         di_q    <= '0;
         an_q    <= 4'b1110;
         seg_q   <= 7'b1111111;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sha_q   <= sha_d;
         shb_q   <= shb_d;
         dig_q   <= dig_d;
         rc_q    <= rc_d;
         di_q    <= di_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign an_o   = an_q;
   assign seg_o  = seg_q;
endmodule

// File: tb/tb_module_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_module_display_ctrl
//   Self-checking bench for module_display_ctrl with REFRESH_DIV = 4.
//   Table-driven operand pairs with a scoreboard of expected digit codes,
//   plus hand-written sequences for reset, scan order, busy-ignore,
//   back-to-back requests and reset during SEL_B.
// -----------------------------------------------------------------------------
module tb_module_display_ctrl;
   localparam int RD = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_i;
   logic [7:0] b_i;
   logic       upd_i;
   logic       busy_o;
   logic       done_o;
   logic [3:0] an_o;
   logic [6:0] seg_o;

   int checks   = 0;
   int failures = 0;

   logic [15:0] sb_q[$];   // expected {d3,d2,d1,d0}

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[5];

   module_display_ctrl #(.REFRESH_DIV(RD)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_i    (a_i),
      .b_i    (b_i),
      .upd_i  (upd_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .an_o   (an_o),
      .seg_o  (seg_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] pat(input logic [3:0] code);
      case (code)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         4'hA:    return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Watch one full scan rotation; each digit's segments are compared the
   // first time its anode is active.
   task automatic check_scan(input string tag, input logic [15:0] e);
      logic [3:0] seen;
      logic [3:0] sel;
      int         idx;
      seen = 4'h0;
      for (int n = 0; n < 4 * RD + 1; n++) begin
         @(negedge clk);
         idx = -1;
         for (int i = 0; i < 4; i++) begin
            sel = ~(4'b0001 << i);
            if (an_o == sel) idx = i;
         end
         if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL %s anode one-hot: got %b", tag, an_o);
         end else if (!seen[idx]) begin
            seen[idx] = 1'b1;
            check($sformatf("%s seg d%0d", tag, idx), {9'd0, seg_o}, {9'd0, pat(e[idx*4 +: 4])});
         end
      end
      check({tag, " all digits scanned"}, {12'd0, seen}, 16'h000F);
   endtask

   // One request; checks busy length, done pulse, then digits via the scan.
   task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
      int          busy_cnt;
      bit          got;
      logic [15:0] e;
      @(negedge clk);
      a_i   = a;
      b_i   = b;
      upd_i = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      upd_i    = 1'b0;
      busy_cnt = 0;
      got      = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (done_o) begin
            got = 1'b1;
            break;
         end
         if (busy_o) busy_cnt++;
         @(negedge clk);
      end
      check({tag, " done seen"}, {15'd0, got}, 16'd1);
      check({tag, " busy cycles"}, 16'(busy_cnt), 16'd2);
      check({tag, " busy low with done"}, {15'd0, busy_o}, 16'd0);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
      @(negedge clk);
      check({tag, " done one cycle"}, {15'd0, done_o}, 16'd0);
      check_scan(tag, e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int          busy_seen;
      int          done_cnt;
      logic [3:0]  exp_an;
      logic [15:0] e;

      vecs[0] = '{a: 8'd45,  b: 8'd81,  exp: 16'h4581};
      vecs[1] = '{a: 8'd150, b: 8'd10,  exp: 16'hAA10};
      vecs[2] = '{a: 8'd5,   b: 8'd0,   exp: 16'h0500};
      vecs[3] = '{a: 8'd99,  b: 8'd255, exp: 16'h99AA};
      vecs[4] = '{a: 8'd0,   b: 8'd99,  exp: 16'h0099};
`ifdef DISPLAY_LZB_EN
      vecs[2].exp = 16'hF5F0;
      vecs[4].exp = 16'hF099;
`else
`endif

      rst_n = 1'b0;
      a_i   = 8'd0;
      b_i   = 8'd0;
      upd_i = 1'b0;

      // Reset values and idle scan order (rc/di start at 0 on release).
      do_reset();
      check("reset an", {12'd0, an_o}, 16'b1110);
      check("reset seg", {9'd0, seg_o}, 16'h007F);
      check("reset busy", {15'd0, busy_o}, 16'd0);
      check("reset done", {15'd0, done_o}, 16'd0);
      busy_seen = 0;
      for (int k = 0; k < 4 * RD; k++) begin
         if (k > 0) @(negedge clk);
         exp_an = ~(4'b0001 << ((k / RD) % 4));
         check($sformatf("idle scan an k=%0d", k), {12'd0, an_o}, {12'd0, exp_an});
         if (busy_o || done_o || seg_o != 7'b1111111) busy_seen++;
      end
      check("no activity before upd", 16'(busy_seen), 16'd0);

      // Table-driven conversions.
      foreach (vecs[i]) begin
         run_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
      end

      // Request during SEL_A with new operands must be ignored.
      @(negedge clk);
      a_i   = 8'd12;
      b_i   = 8'd34;
      upd_i = 1'b1;
      sb_q.push_back(16'h1234);
      @(negedge clk);               // after E0, in SEL_A
      a_i   = 8'd77;
      b_i   = 8'd66;
      upd_i = 1'b1;                 // sampled at E1, ignored
      @(negedge clk);
      upd_i = 1'b0;
      done_cnt = 0;
      for (int n = 0; n < 8; n++) begin
         if (done_o) done_cnt++;
         @(negedge clk);
      end
      check("busy ignore done count", 16'(done_cnt), 16'd1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
      check_scan("busy ignore", e);

      // Back-to-back: upd held high restarts every 3 cycles.
      @(negedge clk);
      a_i   = 8'd63;
      b_i   = 8'd27;
      upd_i = 1'b1;
      sb_q.push_back(16'h6327);
      sb_q.push_back(16'h6327);
      done_cnt = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (done_o) begin
            done_cnt++;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
         end
      end
      upd_i = 1'b0;
      check("back-to-back done count", 16'(done_cnt), 16'd2);
      check("back-to-back idle after", {15'd0, busy_o}, 16'd0);
      check_scan("back-to-back", e);

      // Reset asserted while in SEL_B.
      @(negedge clk);
      a_i   = 8'd42;
      b_i   = 8'd17;
      upd_i = 1'b1;
      @(negedge clk);               // after E0: SEL_A
      upd_i = 1'b0;
      @(negedge clk);               // after E1: SEL_B
      check("pre-reset busy in SEL_B", {15'd0, busy_o}, 16'd1);
      rst_n = 1'b0;
      #1;
      check("mid reset busy", {15'd0, busy_o}, 16'd0);
      check("mid reset done", {15'd0, done_o}, 16'd0);
      check("mid reset an", {12'd0, an_o}, 16'b1110);
      check("mid reset seg", {9'd0, seg_o}, 16'h007F);
      done_cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (done_o) done_cnt++;
      end
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (done_o || busy_o) done_cnt++;
      end
      check("no done after mid reset", 16'(done_cnt), 16'd0);
      check_scan("blank after reset", 16'hFFFF);

      // FSM is back in IDLE and accepts a fresh request.
      run_pair("post reset", 8'd30, 8'd8, 16'h3008);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
